priority_extractor: RTL

- Parametrised successor to the single-shot priority encoder.
- Accepts a WIDTH-bit word through a valid/ready handshake, then emits every set bit, one per beat, as a one-hot plus binary index. Order is LSB-first or MSB-first, selected by parameter.
- Sits between request-vector producers (IRQ pending, free-slot maps) and consumers that service one request at a time with backpressure.

---
 rtl/priority_extractor_pkg.sv | 48 ++++
 rtl/priority_extractor_pick_bit.sv | 46 ++++
 rtl/priority_extractor.sv | 114 +++++++++++
 3 files changed

// File: rtl/priority_extractor_pkg.sv
// priority_extractor_pkg
//   Shared types and helpers for priority_extractor.
//   - state_t       : control FSM encoding (IDLE / ACTIVE)
//   - pe_word_t     : widest word the helpers handle (PE_MAX_W bits). Callers
//                     zero-extend their WIDTH-bit vector on the way in and
//                     size-cast the result back to WIDTH / IDX_W bits.
//   - lsb_onehot    : isolate the lowest set bit (x & -x)
//   - onehot_to_idx : binary position of a one-hot vector (0 for all-zero)
//   - popcount      : number of set bits (only referenced when
//                     PRIORITY_EXTRACTOR_COUNT_EN is defined)
package priority_extractor_pkg;

  // Upper bound on WIDTH for any instance that uses these helpers.
  localparam int PE_MAX_W = 256;

  typedef logic [PE_MAX_W-1:0] pe_word_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Two's-complement trick: -x flips every bit above the lowest one, so the
  // AND keeps only that bit.
  function automatic pe_word_t lsb_onehot(input pe_word_t x);
    return x & (-x);
  endfunction

  // OR-reduction of the positions of set bits; exact for one-hot input.
  function automatic int onehot_to_idx(input pe_word_t oh);
    int idx;
    idx = 0;
    for (int i = 0; i < PE_MAX_W; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  function automatic int popcount(input pe_word_t x);
    int n;
    n = 0;
    for (int i = 0; i < PE_MAX_W; i++) begin
      if (x[i]) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/priority_extractor_pick_bit.sv
// priority_extractor_pick_bit
//   Purely combinational selector: picks the next bit to emit from the
//   remaining mask. MSB-first order reuses the LSB-first logic by
//   bit-reversing the mask on the way in and the one-hot on the way out.
// Ports:
//   i_rem    [WIDTH-1:0]  bits still to be emitted
//   o_onehot [WIDTH-1:0]  selected bit, one-hot (0 when i_rem is 0)
//   o_index  [IDX_W-1:0]  binary position of o_onehot (0 when i_rem is 0)
//   o_last                i_rem holds exactly one set bit
module priority_extractor_pick_bit
  import priority_extractor_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0,
  parameter int IDX_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_rem,
  output logic [WIDTH-1:0] o_onehot,
  output logic [IDX_W-1:0] o_index,
  output logic             o_last
);

  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] w_oh;
  logic [WIDTH-1:0] w_rest;

  generate
    if (MSB_FIRST) begin : g_rev
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_in[i]     = i_rem[WIDTH-1-i];
        assign o_onehot[i] = w_oh[WIDTH-1-i];
      end
    end else begin : g_fwd
      assign w_in     = i_rem;
      assign o_onehot = w_oh;
    end
  endgenerate

  assign w_oh    = WIDTH'(lsb_onehot(PE_MAX_W'(w_in)));
  assign o_index = IDX_W'(onehot_to_idx(PE_MAX_W'(o_onehot)));

  // Last when something is set and nothing survives removing the pick.
  assign w_rest = w_in & ~w_oh;
  assign o_last = (|w_in) & ~(|w_rest);

endmodule

// File: rtl/priority_extractor.sv
// priority_extractor
//   Accepts a WIDTH-bit word over valid/ready and emits each set bit, one per
//   beat, as one-hot + binary index, LSB-first (MSB_FIRST=0) or MSB-first.
//   An all-zero word produces a single beat flagged by zero_o.
//   Outputs are driven only from registered state (no data_i -> output path).
// Ports:
//   clk_i, srst_i        clock, synchronous active-high reset
//   data_i/data_val_i    input word and its valid
//   data_ready_o         a word can be loaded this cycle
//   onehot_o/index_o     current bit, one-hot and binary
//   zero_o               current beat belongs to an all-zero word
//   data_val_o           output beat valid
//   data_last_o          final beat of the current word
//   data_ready_i         downstream accepts the beat
// Optional (macro PRIORITY_EXTRACTOR_COUNT_EN):
//   count_o              popcount of the word, captured at load
//   beat_o               0-based beat number within the word
module priority_extractor
  import priority_extractor_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0,
  parameter int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] index_o,
  output logic             zero_o,
  output logic             data_val_o,
  output logic             data_last_o,
  input  logic             data_ready_i
`ifdef PRIORITY_EXTRACTOR_COUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] count_o,
  output logic [IDX_W:0]             beat_o
`endif
);

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH-1:0] w_onehot;
  logic [IDX_W-1:0] w_index;
  logic             w_pick_last;
  logic             w_active;
  logic             w_rem_zero;
  logic             w_beat_hs;
  logic             w_load;

  priority_extractor_pick_bit #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .IDX_W     (IDX_W)
  ) u_pick (
    .i_rem    (r_rem),
    .o_onehot (w_onehot),
    .o_index  (w_index),
    .o_last   (w_pick_last)
  );

  assign w_active   = (r_state == ACTIVE);
  // An empty mask while ACTIVE can only mean an all-zero word was loaded.
  assign w_rem_zero = ~(|r_rem);

  assign data_val_o  = w_active;
  assign zero_o      = w_active & w_rem_zero;
  assign data_last_o = w_active & (w_pick_last | w_rem_zero);
  // r_rem is 0 in IDLE, so these read as 0 there without extra gating.
  assign onehot_o    = w_onehot;
  assign index_o     = w_index;

  assign w_beat_hs    = data_val_o & data_ready_i;
  // Accept when idle, or when the final beat retires this edge (no bubble).
  assign data_ready_o = ~srst_i & (~w_active | (w_beat_hs & data_last_o));
  assign w_load       = data_val_i & data_ready_o;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= IDLE;
      r_rem   <= '0;
    end else if (w_load) begin
      r_state <= ACTIVE;
      r_rem   <= data_i;
    end else if (w_beat_hs) begin
      r_rem <= r_rem & ~w_onehot;
      if (data_last_o) r_state <= IDLE;
    end
  end

`ifdef PRIORITY_EXTRACTOR_COUNT_EN
  logic [$clog2(WIDTH+1)-1:0] r_count;
  logic [IDX_W:0]             r_beat;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_count <= '0;
      r_beat  <= '0;
    end else if (w_load) begin
      r_count <= ($clog2(WIDTH+1))'(popcount(PE_MAX_W'(data_i)));
      r_beat  <= '0;
    end else if (w_beat_hs) begin
      r_beat <= r_beat + (IDX_W+1)'(1);
    end
  end

  assign count_o = r_count;
  assign beat_o  = r_beat;
`endif

endmodule
